// File: rtl/video_counter_if.sv
// Pixel-enable and H/V count/sync bundle between the video counter and its consumers.
interface video_counter_if;
  logic       CLK_EN;
  logic [8:0] HCNT;
  logic [8:0] VCNT;
  logic       HRESET;
  logic       HRESET_N;
  logic       VRESET;
  logic       VRESET_N;
  logic       LINE_TICK;
  logic       FRAME_TICK;

  modport master (
    output CLK_EN,
    input  HCNT, VCNT, HRESET, HRESET_N, VRESET, VRESET_N, LINE_TICK, FRAME_TICK
  );

  modport slave (
    input  CLK_EN,
    output HCNT, VCNT, HRESET, HRESET_N, VRESET, VRESET_N, LINE_TICK, FRAME_TICK
  );
endinterface

// File: rtl/video_counter.sv
// Synchronous H/V video counter chain with registered line/frame reset pulses and strobes,
// advancing once per pixel-enabled CLK_DRV edge.
module video_counter #(
  parameter int H_TOTAL = 455,
  parameter int V_TOTAL = 262
) (
  input  logic          CLK_DRV,
  input  logic          RESET,
  video_counter_if.slave vif
);

  if (H_TOTAL < 2 || H_TOTAL > 512) begin : g_bad_h_total
    $error("video_counter: H_TOTAL out of range 2..512");
  end
  if (V_TOTAL < 2 || V_TOTAL > 512) begin : g_bad_v_total
    $error("video_counter: V_TOTAL out of range 2..512");
  end

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       hreset_q, hreset_d;
  logic       hreset_n_q, hreset_n_d;
  logic       vreset_q, vreset_d;
  logic       vreset_n_q, vreset_n_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic       h_term_s;
  logic       v_term_s;

  assign h_term_s = (hcnt_q == H_LAST);
  assign v_term_s = (vcnt_q == V_LAST);

  // Strobes default low so they last exactly one CLK_DRV cycle whatever the enable duty.
  always_comb begin
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    hreset_d     = hreset_q;
    hreset_n_d   = hreset_n_q;
    vreset_d     = vreset_q;
    vreset_n_d   = vreset_n_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    if (vif.CLK_EN) begin
      hcnt_d       = h_term_s ? 9'd0 : hcnt_q + 9'd1;
      hreset_d     = h_term_s;
      hreset_n_d   = ~h_term_s;
      line_tick_d  = h_term_s;
      frame_tick_d = h_term_s & v_term_s;
      if (h_term_s) begin
        vcnt_d     = v_term_s ? 9'd0 : vcnt_q + 9'd1;
        vreset_d   = v_term_s;
        vreset_n_d = ~v_term_s;
      end else begin
        vcnt_d     = vcnt_q;
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      hcnt_q       <= 9'd0;
      vcnt_q       <= 9'd0;
      hreset_q     <= 1'b0;
      hreset_n_q   <= 1'b1;
      vreset_q     <= 1'b0;
      vreset_n_q   <= 1'b1;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hreset_q     <= hreset_d;
      hreset_n_q   <= hreset_n_d;
      vreset_q     <= vreset_d;
      vreset_n_q   <= vreset_n_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vif.HCNT       = hcnt_q;
  assign vif.VCNT       = vcnt_q;
  assign vif.HRESET     = hreset_q;
  assign vif.HRESET_N   = hreset_n_q;
  assign vif.VRESET     = vreset_q;
  assign vif.VRESET_N   = vreset_n_q;
  assign vif.LINE_TICK  = line_tick_q;
  assign vif.FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_video_counter.sv
// Bench for video_counter: a default-size and an 8x3 instance share clock, reset and enable and
// are compared each cycle against a model derived from the count of enabled ticks since reset.
module tb_video_counter;

  localparam int HA = 455;
  localparam int VA = 262;
  localparam int HB = 8;
  localparam int VB = 3;
  localparam logic [23:0] RESET_VEC = {9'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  int     checks   = 0;
  int     failures = 0;
  longint n        = 0;
  bit     last_en  = 1'b0;

  video_counter_if vif_a ();
  video_counter_if vif_b ();

  assign vif_a.CLK_EN = en;
  assign vif_b.CLK_EN = en;

  video_counter #(.H_TOTAL(HA), .V_TOTAL(VA)) dut_a (.CLK_DRV(clk), .RESET(rst), .vif(vif_a));
  video_counter #(.H_TOTAL(HB), .V_TOTAL(VB)) dut_b (.CLK_DRV(clk), .RESET(rst), .vif(vif_b));

  always #5 clk = ~clk;

  logic [23:0] obs_a, obs_b;
  assign obs_a = {vif_a.HCNT, vif_a.VCNT, vif_a.HRESET, vif_a.HRESET_N,
                  vif_a.VRESET, vif_a.VRESET_N, vif_a.LINE_TICK, vif_a.FRAME_TICK};
  assign obs_b = {vif_b.HCNT, vif_b.VCNT, vif_b.HRESET, vif_b.HRESET_N,
                  vif_b.VRESET, vif_b.VRESET_N, vif_b.LINE_TICK, vif_b.FRAME_TICK};

  // Expected outputs from n enabled ticks since reset: position is n mod frame, pulses follow a wrap.
  function automatic logic [23:0] model(int h, int v);
    longint line;
    int     hc, vc;
    bit     hr, vr, lt, ft;
    hc   = int'(n % h);
    line = n / h;
    vc   = int'(line % v);
    hr   = (n > 0) && (hc == 0);
    vr   = (line >= v) && (vc == 0);
    lt   = last_en && hr;
    ft   = last_en && (n > 0) && ((n % (h * v)) == 0);
    return {9'(hc), 9'(vc), hr, !hr, vr, !vr, lt, ft};
  endfunction

  // One CLK_DRV cycle: drive enable at the falling edge, account for the rising edge, sample at next fall.
  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    if (e) n = n + 1;
    last_en = e;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    n       = 0;
    last_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 2;
    if (obs_a !== RESET_VEC) begin
      failures++; $display("FAIL reset_a got=%h want=%h", obs_a, RESET_VEC);
    end
    if (obs_b !== RESET_VEC) begin
      failures++; $display("FAIL reset_b got=%h want=%h", obs_b, RESET_VEC);
    end
    rst = 1'b0;
    n = 0; last_en = 1'b0;
  endtask

  task automatic test_line();
    for (int i = 0; i < HA; i++) begin
      step(1'b1);
      checks += 2;
      if (obs_a !== model(HA, VA)) begin
        failures++; $display("FAIL line_a tick=%0d got=%h want=%h", i, obs_a, model(HA, VA));
      end
      if (obs_b !== model(HB, VB)) begin
        failures++; $display("FAIL line_b tick=%0d got=%h want=%h", i, obs_b, model(HB, VB));
      end
    end
    checks++;
    if (vif_a.VCNT !== 9'd1 || vif_a.HCNT !== 9'd0 || vif_a.HRESET !== 1'b1 || vif_a.LINE_TICK !== 1'b1) begin
      failures++;
      $display("FAIL line_end got h=%0d v=%0d hr=%b lt=%b want h=0 v=1 hr=1 lt=1",
               vif_a.HCNT, vif_a.VCNT, vif_a.HRESET, vif_a.LINE_TICK);
    end
  endtask

  task automatic test_duty();
    for (int i = 0; i < 2000; i++) begin
      step((i % 4) == 0);
      checks += 2;
      if (obs_a !== model(HA, VA)) begin
        failures++; $display("FAIL duty_a cyc=%0d got=%h want=%h", i, obs_a, model(HA, VA));
      end
      if (obs_b !== model(HB, VB)) begin
        failures++; $display("FAIL duty_b cyc=%0d got=%h want=%h", i, obs_b, model(HB, VB));
      end
    end
  endtask

  task automatic test_en_hold();
    for (int i = 0; i < HA && (n % HA) != HA - 1; i++) step(1'b1);
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      checks += 2;
      if (vif_a.HCNT !== 9'd454 || vif_a.HRESET !== 1'b0 || vif_a.LINE_TICK !== 1'b0) begin
        failures++;
        $display("FAIL hold_454 cyc=%0d got h=%0d hr=%b lt=%b want h=454 hr=0 lt=0",
                 i, vif_a.HCNT, vif_a.HRESET, vif_a.LINE_TICK);
      end
      if (obs_b !== model(HB, VB)) begin
        failures++; $display("FAIL hold_b cyc=%0d got=%h want=%h", i, obs_b, model(HB, VB));
      end
    end
    step(1'b1);
    checks++;
    if (vif_a.HCNT !== 9'd0 || vif_a.HRESET !== 1'b1 || vif_a.HRESET_N !== 1'b0 || vif_a.LINE_TICK !== 1'b1) begin
      failures++;
      $display("FAIL hold_wrap got h=%0d hr=%b hrn=%b lt=%b want h=0 hr=1 hrn=0 lt=1",
               vif_a.HCNT, vif_a.HRESET, vif_a.HRESET_N, vif_a.LINE_TICK);
    end
    step(1'b0);
    checks++;
    if (vif_a.HRESET !== 1'b1 || vif_a.LINE_TICK !== 1'b0) begin
      failures++;
      $display("FAIL strobe_width got hr=%b lt=%b want hr=1 lt=0", vif_a.HRESET, vif_a.LINE_TICK);
    end
  endtask

  task automatic test_small_frame();
    int frames = 0;
    int first_ft = -1;
    do_reset();
    for (int i = 1; i <= 10 * HB * VB; i++) begin
      step(1'b1);
      if (vif_b.FRAME_TICK === 1'b1) begin
        frames++;
        if (first_ft < 0) first_ft = i;
      end
      checks++;
      if (obs_b !== model(HB, VB)) begin
        failures++; $display("FAIL frame_b tick=%0d got=%h want=%h", i, obs_b, model(HB, VB));
      end
    end
    checks += 2;
    if (frames !== 10) begin
      failures++; $display("FAIL frame_count got=%0d want=10", frames);
    end
    if (first_ft !== 24) begin
      failures++; $display("FAIL frame_period got=%0d want=24", first_ft);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)));
      checks += 2;
      if (obs_a !== model(HA, VA)) begin
        failures++; $display("FAIL rand_a cyc=%0d got=%h want=%h", i, obs_a, model(HA, VA));
      end
      if (obs_b !== model(HB, VB)) begin
        failures++; $display("FAIL rand_b cyc=%0d got=%h want=%h", i, obs_b, model(HB, VB));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 100 * HA + 200; i++) begin
      step(1'b1);
      if ((i % 97) == 0) begin
        checks++;
        if (obs_a !== model(HA, VA)) begin
          failures++; $display("FAIL run_a tick=%0d got=%h want=%h", i, obs_a, model(HA, VA));
        end
      end
    end
    checks++;
    if (vif_a.HCNT !== 9'd200 || vif_a.VCNT !== 9'd100) begin
      failures++; $display("FAIL pre_reset got h=%0d v=%0d want h=200 v=100", vif_a.HCNT, vif_a.VCNT);
    end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (obs_a !== RESET_VEC) begin
      failures++; $display("FAIL async_reset_a got=%h want=%h", obs_a, RESET_VEC);
    end
    if (obs_b !== RESET_VEC) begin
      failures++; $display("FAIL async_reset_b got=%h want=%h", obs_b, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0; last_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      checks++;
      if (obs_a !== model(HA, VA)) begin
        failures++; $display("FAIL resume_a tick=%0d got=%h want=%h", i, obs_a, model(HA, VA));
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_duty();
    test_en_hold();
    test_small_frame();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
